// File: rtl/m_csr_pkg.sv
// Shared definitions for the machine/supervisor CSR and trap unit.
// Holds the CSR addresses, privilege encodings, csr_ops/sys_ops encodings,
// exception and interrupt cause codes, mstatus field positions, and the
// mstatus write-legalisation helper.
package m_csr_pkg;

  localparam logic [11:0] CSR_SSTATUS   = 12'h100;
  localparam logic [11:0] CSR_SEPC      = 12'h141;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam logic [1:0] PRIV_MODE_U = 2'b00;
  localparam logic [1:0] PRIV_MODE_S = 2'b01;
  localparam logic [1:0] PRIV_MODE_M = 2'b11;

  localparam logic [1:0] CSR_OP_NONE  = 2'b00;
  localparam logic [1:0] CSR_OP_WRITE = 2'b01;
  localparam logic [1:0] CSR_OP_SET   = 2'b10;
  localparam logic [1:0] CSR_OP_CLEAR = 2'b11;

  localparam logic [2:0] SYS_OPS_NONE       = 3'b000;
  localparam logic [2:0] SYS_OPS_SRET       = 3'b001;
  localparam logic [2:0] SYS_OPS_WFI        = 3'b010;
  localparam logic [2:0] SYS_OPS_MRET       = 3'b011;
  localparam logic [2:0] SYS_OPS_SFENCE_VMA = 3'b100;

  localparam logic [3:0] EXC_CODE_ILLEGAL = 4'd2;
  localparam logic [3:0] EXC_CODE_ECALL_U = 4'd8;
  localparam logic [3:0] EXC_CODE_ECALL_S = 4'd9;
  localparam logic [3:0] EXC_CODE_ECALL_M = 4'd11;
  localparam logic [3:0] INT_CODE_MTI     = 4'd7;
  localparam logic [3:0] INT_CODE_MEI     = 4'd11;

  typedef enum logic [4:0] {
    MS_SIE    = 5'd1,
    MS_MIE    = 5'd3,
    MS_SPIE   = 5'd5,
    MS_MPIE   = 5'd7,
    MS_SPP    = 5'd8,
    MS_MPP_LO = 5'd11,
    MS_MPP_HI = 5'd12
  } mstatus_bit_e;

  localparam logic [31:0] MSTATUS_MASK = 32'h0000_19AA;
  localparam logic [31:0] SSTATUS_MASK = 32'h0000_0122;
  localparam logic [31:0] MIE_MASK     = 32'h0000_0880;

  typedef enum logic {ST_RUN, ST_WAIT} wfi_state_e;

  // MPP = 2'b10 is reserved; fold it to U so MRET can never enter it.
  function automatic logic [31:0] mstatus_wr(input logic [31:0] v);
    logic [31:0] r;
    r = v & MSTATUS_MASK;
    if (r[12:11] == 2'b10) r[12:11] = PRIV_MODE_U;
    return r;
  endfunction

endpackage

// File: rtl/m_csr_trap_unit_if.sv
// Execute-stage <-> CSR/trap unit signal bundle.
// master: pipeline side (drives instruction controls and interrupt levels).
// slave : the CSR/trap unit (returns read data, privilege, redirect, stall).
interface m_csr_trap_unit_if;
  logic        instr_valid;
  logic [31:0] pc;
  logic [1:0]  csr_ops;
  logic [2:0]  sys_ops;
  logic        exc_req;
  logic [3:0]  exc_code;
  logic [31:0] exc_tval;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        mtip;
  logic        meip;
  logic [31:0] csr_rdata;
  logic [1:0]  priv_mode;
  logic        trap_taken;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;

  modport master (
    output instr_valid, pc, csr_ops, sys_ops, exc_req, exc_code, exc_tval,
           csr_addr, csr_wdata, mtip, meip,
    input  csr_rdata, priv_mode, trap_taken, redirect_valid, redirect_pc, stall
  );

  modport slave (
    input  instr_valid, pc, csr_ops, sys_ops, exc_req, exc_code, exc_tval,
           csr_addr, csr_wdata, mtip, meip,
    output csr_rdata, priv_mode, trap_taken, redirect_valid, redirect_pc, stall
  );
endinterface

// File: rtl/m_csr_counter64.sv
// 64-bit wrapping counter with increment enable and independent 32-bit
// half writes. A write to either half suppresses the increment that cycle.
// Ports: clk, reset (async high), inc, wr_lo, wr_hi, wdata[31:0], count[63:0].
module m_csr_counter64 (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      count         <= '0;
    else if (wr_lo) count[31:0]   <= wdata;
    else if (wr_hi) count[63:32]  <= wdata;
    else if (inc)   count         <= count + 64'd1;
  end
endmodule

// File: rtl/m_csr_trap_unit.sv
// Machine/supervisor CSR file, privilege state, trap/xRET resolution and
// WFI stall for the execute stage.
// Ports: clk, reset (async high), bus (m_csr_trap_unit_if.slave): instruction
// controls and interrupt levels in; csr_rdata, priv_mode, trap_taken,
// redirect_valid/redirect_pc and stall out.
module m_csr_trap_unit
  import m_csr_pkg::*;
#(
  parameter logic [31:0] RESET_TVEC = 32'h0000_0000,
  parameter logic [31:0] MISA_VAL   = 32'h4014_1100,
  parameter logic [31:0] HART_ID    = 32'd0
) (
  input  logic           clk,
  input  logic           reset,
  m_csr_trap_unit_if.slave bus
);
  logic [1:0]  priv;
  logic [31:0] mstatus, mie_r, mtvec, mscratch, mepc, mcause, mtval, sepc;
  wfi_state_e  state;
  logic [63:0] mcycle, minstret;
  logic [31:0] mip, pending, csr_val, csr_wval, tvec_base, trap_pc;
  logic        csr_known, wr_attempt, csr_illegal, sys_illegal;
  logic        int_en, int_take, exc_take, ill_take, trap, retire, csr_we;
  logic        mret_do, sret_do, wfi_do;
  logic [3:0]  trap_code;

  assign mip     = {20'b0, bus.meip, 3'b0, bus.mtip, 7'b0};
  assign pending = mip & mie_r;

  always_comb begin
    csr_val   = '0;
    csr_known = 1'b1;
    case (bus.csr_addr)
      CSR_MSTATUS:             csr_val = mstatus;
      CSR_SSTATUS:             csr_val = mstatus & SSTATUS_MASK;
      CSR_MISA:                csr_val = MISA_VAL;
      CSR_MIE:                 csr_val = mie_r;
      CSR_MTVEC:               csr_val = mtvec;
      CSR_MSCRATCH:            csr_val = mscratch;
      CSR_MEPC:                csr_val = mepc;
      CSR_SEPC:                csr_val = sepc;
      CSR_MCAUSE:              csr_val = mcause;
      CSR_MTVAL:               csr_val = mtval;
      CSR_MIP:                 csr_val = mip;
      CSR_MCYCLE, CSR_CYCLE:   csr_val = mcycle[31:0];
      CSR_MCYCLEH, CSR_CYCLEH: csr_val = mcycle[63:32];
      CSR_MINSTRET:            csr_val = minstret[31:0];
      CSR_MINSTRETH:           csr_val = minstret[63:32];
      CSR_MHARTID:             csr_val = HART_ID;
      default:                 csr_known = 1'b0;
    endcase
  end

  // set/clear with a zero mask is a pure read.
  assign wr_attempt = (bus.csr_ops == CSR_OP_WRITE) ||
                      (((bus.csr_ops == CSR_OP_SET) || (bus.csr_ops == CSR_OP_CLEAR)) &&
                       (bus.csr_wdata != '0));

  assign csr_illegal = (bus.csr_ops != CSR_OP_NONE) &&
                       (!csr_known || (bus.csr_addr[9:8] > priv) ||
                        (wr_attempt && (bus.csr_addr[11:10] == 2'b11)));
  assign sys_illegal = ((bus.sys_ops == SYS_OPS_MRET) && (priv != PRIV_MODE_M)) ||
                       (((bus.sys_ops == SYS_OPS_SRET) || (bus.sys_ops == SYS_OPS_SFENCE_VMA)) &&
                        (priv == PRIV_MODE_U));

  assign int_en   = (priv != PRIV_MODE_M) || mstatus[MS_MIE];
  assign int_take = bus.instr_valid && (pending != '0) && int_en;
  assign exc_take = bus.instr_valid && !int_take && bus.exc_req;
  assign ill_take = bus.instr_valid && !int_take && !bus.exc_req && (csr_illegal || sys_illegal);
  assign trap     = int_take || exc_take || ill_take;
  assign retire   = bus.instr_valid && !trap;

  assign trap_code = int_take    ? (pending[11] ? INT_CODE_MEI : INT_CODE_MTI) :
                     bus.exc_req ? bus.exc_code : EXC_CODE_ILLEGAL;

  assign mret_do = retire && (bus.sys_ops == SYS_OPS_MRET);
  assign sret_do = retire && (bus.sys_ops == SYS_OPS_SRET);
  assign wfi_do  = retire && (bus.sys_ops == SYS_OPS_WFI);

  // Only interrupts use the vectored offset; exceptions always go to base.
  assign tvec_base = mtvec & ~32'h3;
  assign trap_pc   = ((mtvec[1:0] == 2'b01) && int_take) ?
                     tvec_base + {26'b0, trap_code, 2'b00} : tvec_base;

  always_comb begin
    case (bus.csr_ops)
      CSR_OP_WRITE: csr_wval = bus.csr_wdata;
      CSR_OP_SET:   csr_wval = csr_val | bus.csr_wdata;
      CSR_OP_CLEAR: csr_wval = csr_val & ~bus.csr_wdata;
      default:      csr_wval = csr_val;
    endcase
  end
  assign csr_we = retire && wr_attempt;

  assign bus.csr_rdata      = (bus.csr_ops != CSR_OP_NONE) ? csr_val : '0;
  assign bus.priv_mode      = priv;
  assign bus.trap_taken     = trap;
  assign bus.redirect_valid = trap || mret_do || sret_do;
  assign bus.redirect_pc    = trap ? trap_pc : mret_do ? mepc : sret_do ? sepc : '0;
  // Wake-up releases fetch in the same cycle the interrupt becomes pending.
  assign bus.stall          = (state == ST_WAIT) && (pending == '0);

  m_csr_counter64 u_mcycle (
    .clk   (clk),
    .reset (reset),
    .inc   (1'b1),
    .wr_lo (csr_we && (bus.csr_addr == CSR_MCYCLE)),
    .wr_hi (csr_we && (bus.csr_addr == CSR_MCYCLEH)),
    .wdata (csr_wval),
    .count (mcycle)
  );

  m_csr_counter64 u_minstret (
    .clk   (clk),
    .reset (reset),
    .inc   (retire),
    .wr_lo (csr_we && (bus.csr_addr == CSR_MINSTRET)),
    .wr_hi (csr_we && (bus.csr_addr == CSR_MINSTRETH)),
    .wdata (csr_wval),
    .count (minstret)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      priv     <= PRIV_MODE_M;
      mstatus  <= '0;
      mie_r    <= '0;
      mtvec    <= RESET_TVEC;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mtval    <= '0;
      sepc     <= '0;
      state    <= ST_RUN;
    end else begin
      if (csr_we) begin
        case (bus.csr_addr)
          CSR_MSTATUS:  mstatus  <= mstatus_wr(csr_wval);
          CSR_SSTATUS:  mstatus  <= (mstatus & ~SSTATUS_MASK) | (csr_wval & SSTATUS_MASK);
          CSR_MIE:      mie_r    <= csr_wval & MIE_MASK;
          CSR_MTVEC:    mtvec    <= {csr_wval[31:2], 1'b0, csr_wval[0]};
          CSR_MSCRATCH: mscratch <= csr_wval;
          CSR_MEPC:     mepc     <= csr_wval & ~32'h3;
          CSR_SEPC:     sepc     <= csr_wval & ~32'h3;
          CSR_MCAUSE:   mcause   <= csr_wval;
          CSR_MTVAL:    mtval    <= csr_wval;
          default: ;
        endcase
      end

      case (state)
        ST_RUN:  if (wfi_do) state <= ST_WAIT;
        ST_WAIT: if (pending != '0) state <= ST_RUN;
        default: state <= ST_RUN;
      endcase

      if (trap) begin
        mepc             <= bus.pc & ~32'h3;
        mcause           <= {int_take, 27'b0, trap_code};
        mtval            <= exc_take ? bus.exc_tval : '0;
        mstatus[MS_MPIE] <= mstatus[MS_MIE];
        mstatus[MS_MIE]  <= 1'b0;
        mstatus[12:11]   <= priv;
        priv             <= PRIV_MODE_M;
      end else if (mret_do) begin
        priv             <= mstatus[12:11];
        mstatus[MS_MIE]  <= mstatus[MS_MPIE];
        mstatus[MS_MPIE] <= 1'b1;
        mstatus[12:11]   <= PRIV_MODE_U;
      end else if (sret_do) begin
        priv             <= mstatus[MS_SPP] ? PRIV_MODE_S : PRIV_MODE_U;
        mstatus[MS_SIE]  <= mstatus[MS_SPIE];
        mstatus[MS_SPIE] <= 1'b1;
        mstatus[MS_SPP]  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_m_csr_trap_unit.sv
module tb_m_csr_trap_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  m_csr_trap_unit_if bus();

  m_csr_trap_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic [1:0]  op;
    logic [2:0]  sys;
    logic        er;
    logic [3:0]  ec;
    logic [31:0] tv;
    logic [11:0] addr;
    logic [31:0] wd;
    logic        tip;
    logic        eip;
    logic [31:0] e_rdata;
    logic [1:0]  e_priv;
    logic        e_trap;
    logic        e_rv;
    logic [31:0] e_rpc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic iv, input logic [31:0] pc, input logic [1:0] op,
                     input logic [2:0] sys, input logic er, input logic [3:0] ec,
                     input logic [31:0] tv, input logic [11:0] addr, input logic [31:0] wd,
                     input logic tip, input logic eip, input logic [31:0] e_rdata,
                     input logic [1:0] e_priv, input logic e_trap, input logic e_rv,
                     input logic [31:0] e_rpc);
    vec_t v;
    v.iv = iv; v.pc = pc; v.op = op; v.sys = sys; v.er = er; v.ec = ec; v.tv = tv;
    v.addr = addr; v.wd = wd; v.tip = tip; v.eip = eip; v.e_rdata = e_rdata;
    v.e_priv = e_priv; v.e_trap = e_trap; v.e_rv = e_rv; v.e_rpc = e_rpc;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.instr_valid = v.iv;  bus.pc = v.pc;   bus.csr_ops = v.op; bus.sys_ops = v.sys;
    bus.exc_req = v.er;      bus.exc_code = v.ec; bus.exc_tval = v.tv;
    bus.csr_addr = v.addr;   bus.csr_wdata = v.wd; bus.mtip = v.tip; bus.meip = v.eip;
  endtask

  task automatic idle();
    bus.instr_valid = 0; bus.pc = '0; bus.csr_ops = 0; bus.sys_ops = 0; bus.exc_req = 0;
    bus.exc_code = 0; bus.exc_tval = '0; bus.csr_addr = '0; bus.csr_wdata = '0;
  endtask

  // single instruction: drive, sample mid-cycle, commit on the next edge
  task automatic instr(input logic [1:0] op, input logic [2:0] sys, input logic er,
                       input logic [11:0] addr, input logic [31:0] wd);
    idle();
    bus.instr_valid = 1; bus.pc = 32'h1000; bus.csr_ops = op; bus.sys_ops = sys;
    bus.exc_req = er; bus.exc_code = 4'd11; bus.csr_addr = addr; bus.csr_wdata = wd;
    #4;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  initial begin
    idle();
    bus.mtip = 0; bus.meip = 0;

    //  iv pc          op    sys   er ec  tval          addr    wdata         tip eip  rdata         priv  trap rv rpc
    add(1, 32'h0,      2'b10,3'd0, 0, 0,  32'h0,        12'h305,32'h0,        0, 0,  32'h0,        2'd3, 0, 0, 32'h0);
    add(1, 32'h0,      2'b01,3'd0, 0, 0,  32'h0,        12'h340,32'hDEADBEEF, 0, 0,  32'h0,        2'd3, 0, 0, 32'h0);
    add(1, 32'h0,      2'b10,3'd0, 0, 0,  32'h0,        12'h340,32'h0000000F, 0, 0,  32'hDEADBEEF, 2'd3, 0, 0, 32'h0);
    add(1, 32'h0,      2'b10,3'd0, 0, 0,  32'h0,        12'h340,32'h0,        0, 0,  32'hDEADBEEF, 2'd3, 0, 0, 32'h0);
    add(1, 32'h0,      2'b01,3'd0, 0, 0,  32'h0,        12'h305,32'h200,      0, 0,  32'h0,        2'd3, 0, 0, 32'h0);
    add(1, 32'h0,      2'b10,3'd0, 0, 0,  32'h0,        12'h300,32'h8,        0, 0,  32'h0,        2'd3, 0, 0, 32'h0);
    add(1, 32'h0,      2'b10,3'd0, 0, 0,  32'h0,        12'h300,32'h0,        0, 0,  32'h8,        2'd3, 0, 0, 32'h0);
    add(1, 32'h100,    2'b00,3'd0, 1, 11, 32'h0,        12'h000,32'h0,        0, 0,  32'h0,        2'd3, 1, 1, 32'h200);
    add(1, 32'h0,      2'b10,3'd0, 0, 0,  32'h0,        12'h341,32'h0,        0, 0,  32'h100,      2'd3, 0, 0, 32'h0);
    add(1, 32'h0,      2'b10,3'd0, 0, 0,  32'h0,        12'h342,32'h0,        0, 0,  32'hB,        2'd3, 0, 0, 32'h0);
    add(1, 32'h0,      2'b10,3'd0, 0, 0,  32'h0,        12'h300,32'h0,        0, 0,  32'h1880,     2'd3, 0, 0, 32'h0);
    add(1, 32'h200,    2'b00,3'd3, 0, 0,  32'h0,        12'h000,32'h0,        0, 0,  32'h0,        2'd3, 0, 1, 32'h100);
    add(1, 32'h0,      2'b10,3'd0, 0, 0,  32'h0,        12'h300,32'h0,        0, 0,  32'h88,       2'd3, 0, 0, 32'h0);
    add(1, 32'h104,    2'b00,3'd3, 0, 0,  32'h0,        12'h000,32'h0,        0, 0,  32'h0,        2'd3, 0, 1, 32'h100);
    add(1, 32'h300,    2'b10,3'd0, 0, 0,  32'h0,        12'h300,32'h0,        0, 0,  32'h88,       2'd0, 1, 1, 32'h200);
    add(1, 32'h0,      2'b10,3'd0, 0, 0,  32'h0,        12'h342,32'h0,        0, 0,  32'h2,        2'd3, 0, 0, 32'h0);
    add(1, 32'h0,      2'b10,3'd0, 0, 0,  32'h0,        12'h300,32'h0,        0, 0,  32'h80,       2'd3, 0, 0, 32'h0);
    add(1, 32'h0,      2'b10,3'd0, 0, 0,  32'h0,        12'h343,32'h0,        0, 0,  32'h0,        2'd3, 0, 0, 32'h0);
    add(1, 32'h0,      2'b10,3'd0, 0, 0,  32'h0,        12'h300,32'h8,        0, 0,  32'h80,       2'd3, 0, 0, 32'h0);
    add(1, 32'h0,      2'b01,3'd0, 0, 0,  32'h0,        12'h304,32'h880,      0, 0,  32'h0,        2'd3, 0, 0, 32'h0);
    add(1, 32'h0,      2'b01,3'd0, 0, 0,  32'h0,        12'h305,32'h201,      0, 0,  32'h200,      2'd3, 0, 0, 32'h0);
    add(1, 32'h400,    2'b01,3'd0, 0, 0,  32'h0,        12'h340,32'h12345678, 1, 1,  32'hDEADBEEF, 2'd3, 1, 1, 32'h22C);
    add(1, 32'h0,      2'b10,3'd0, 0, 0,  32'h0,        12'h340,32'h0,        1, 1,  32'hDEADBEEF, 2'd3, 0, 0, 32'h0);
    add(1, 32'h0,      2'b10,3'd0, 0, 0,  32'h0,        12'h342,32'h0,        1, 1,  32'h8000000B, 2'd3, 0, 0, 32'h0);
    add(1, 32'h0,      2'b10,3'd0, 0, 0,  32'h0,        12'h344,32'h0,        1, 1,  32'h880,      2'd3, 0, 0, 32'h0);
    add(1, 32'h0,      2'b10,3'd0, 0, 0,  32'h0,        12'h341,32'h0,        0, 0,  32'h400,      2'd3, 0, 0, 32'h0);
    add(1, 32'h500,    2'b00,3'd0, 1, 5,  32'hCAFE0000, 12'h000,32'h0,        0, 0,  32'h0,        2'd3, 1, 1, 32'h200);
    add(1, 32'h0,      2'b10,3'd0, 0, 0,  32'h0,        12'h343,32'h0,        0, 0,  32'hCAFE0000, 2'd3, 0, 0, 32'h0);
    add(1, 32'h0,      2'b01,3'd0, 0, 0,  32'h0,        12'hF14,32'h1,        0, 0,  32'h0,        2'd3, 1, 1, 32'h200);
    add(1, 32'h0,      2'b10,3'd0, 0, 0,  32'h0,        12'h301,32'h0,        0, 0,  32'h40141100, 2'd3, 0, 0, 32'h0);
    add(1, 32'h0,      2'b10,3'd0, 0, 0,  32'h0,        12'h7C0,32'h0,        0, 0,  32'h0,        2'd3, 1, 1, 32'h200);
    add(1, 32'h0,      2'b10,3'd0, 0, 0,  32'h0,        12'h342,32'h0,        0, 0,  32'h2,        2'd3, 0, 0, 32'h0);
    add(1, 32'h0,      2'b01,3'd0, 0, 0,  32'h0,        12'h141,32'h603,      0, 0,  32'h0,        2'd3, 0, 0, 32'h0);
    add(1, 32'h10,     2'b00,3'd1, 0, 0,  32'h0,        12'h000,32'h0,        0, 0,  32'h0,        2'd3, 0, 1, 32'h600);
    add(1, 32'h20,     2'b00,3'd4, 0, 0,  32'h0,        12'h000,32'h0,        0, 0,  32'h0,        2'd0, 1, 1, 32'h200);
    add(1, 32'h0,      2'b10,3'd0, 0, 0,  32'h0,        12'h342,32'h0,        0, 0,  32'h2,        2'd3, 0, 0, 32'h0);
    add(1, 32'h0,      2'b10,3'd0, 0, 0,  32'h0,        12'h100,32'h0,        0, 0,  32'h20,       2'd3, 0, 0, 32'h0);

    // reset state
    #12;
    chk("reset priv_mode", 32'(bus.priv_mode), 32'h3);
    chk("reset trap_taken", 32'(bus.trap_taken), 32'h0);
    chk("reset redirect_valid", 32'(bus.redirect_valid), 32'h0);
    chk("reset redirect_pc", bus.redirect_pc, 32'h0);
    chk("reset stall", 32'(bus.stall), 32'h0);
    chk("reset csr_rdata", bus.csr_rdata, 32'h0);
    @(posedge clk); #1;
    reset = 0;

    foreach (tbl[i]) begin
      drive(tbl[i]);
      #4;
      chk($sformatf("row%0d rdata", i), bus.csr_rdata, tbl[i].e_rdata);
      chk($sformatf("row%0d priv", i), 32'(bus.priv_mode), 32'(tbl[i].e_priv));
      chk($sformatf("row%0d trap", i), 32'(bus.trap_taken), 32'(tbl[i].e_trap));
      chk($sformatf("row%0d redirect_valid", i), 32'(bus.redirect_valid), 32'(tbl[i].e_rv));
      if (tbl[i].e_rv) chk($sformatf("row%0d redirect_pc", i), bus.redirect_pc, tbl[i].e_rpc);
      next();
    end
    idle(); bus.mtip = 0; bus.meip = 0;

    // WFI with MTIE=1, MIE=0: stall until mtip, no trap on wake-up
    instr(2'b01, 3'd0, 0, 12'h304, 32'h80); next();
    instr(2'b11, 3'd0, 0, 12'h300, 32'h8);  next();
    instr(2'b00, 3'd2, 0, 12'h000, 32'h0);
    chk("wfi issue trap", 32'(bus.trap_taken), 32'h0);
    chk("wfi issue stall", 32'(bus.stall), 32'h0);
    next(); idle();
    for (int c = 0; c < 10; c++) begin
      #4; chk($sformatf("wfi stall c%0d", c), 32'(bus.stall), 32'h1); next();
    end
    bus.mtip = 1; #1;
    chk("wfi wake stall", 32'(bus.stall), 32'h0);
    chk("wfi wake trap", 32'(bus.trap_taken), 32'h0);
    chk("wfi wake redirect", 32'(bus.redirect_valid), 32'h0);
    next();
    instr(2'b00, 3'd0, 0, 12'h000, 32'h0);
    chk("post-wfi masked int trap", 32'(bus.trap_taken), 32'h0);
    chk("post-wfi stall", 32'(bus.stall), 32'h0);
    next(); bus.mtip = 0;

    // reset while waiting
    instr(2'b00, 3'd2, 0, 12'h000, 32'h0); next(); idle(); #4;
    chk("wfi2 stall", 32'(bus.stall), 32'h1);
    reset = 1; #1;
    chk("reset mid-wfi stall", 32'(bus.stall), 32'h0);
    chk("reset mid-wfi priv", 32'(bus.priv_mode), 32'h3);
    next(); reset = 0;
    instr(2'b10, 3'd0, 0, 12'h304, 32'h0);
    chk("mie after reset", bus.csr_rdata, 32'h0);
    next();

    // mcycle carry across halves
    instr(2'b01, 3'd0, 0, 12'hB00, 32'hFFFFFFFF); next();
    instr(2'b01, 3'd0, 0, 12'hB80, 32'h0); next();
    instr(2'b10, 3'd0, 0, 12'hB80, 32'h0);
    chk("mcycleh before carry", bus.csr_rdata, 32'h0);
    next();
    instr(2'b10, 3'd0, 0, 12'hB80, 32'h0);
    chk("mcycleh after carry", bus.csr_rdata, 32'h1);
    next();
    instr(2'b10, 3'd0, 0, 12'hC00, 32'h0);
    chk("cycle alias lo", bus.csr_rdata, 32'h1);
    next();

    // minstret frozen by traps
    instr(2'b01, 3'd0, 0, 12'hB02, 32'h0); next();
    instr(2'b00, 3'd0, 1, 12'h000, 32'h0);
    chk("minstret trap1", 32'(bus.trap_taken), 32'h1);
    next();
    instr(2'b00, 3'd0, 1, 12'h000, 32'h0);
    chk("minstret trap2", 32'(bus.trap_taken), 32'h1);
    next();
    instr(2'b10, 3'd0, 0, 12'hB02, 32'h0);
    chk("minstret after traps", bus.csr_rdata, 32'h0);
    next();
    instr(2'b10, 3'd0, 0, 12'hB02, 32'h0);
    chk("minstret after retire", bus.csr_rdata, 32'h1);
    next();
    instr(2'b10, 3'd0, 0, 12'hB82, 32'h0);
    chk("minstreth", bus.csr_rdata, 32'h0);
    next(); idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
